// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM sequencer and the PWM generator.
package motor_pkg;

   localparam int unsigned DUTY_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      DEAD  = 2'd2,
      ESTOP = 2'd3
   } state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Clearable modulo-N tick counter; N is the step or dead-time length.
module ramp_tick_gen #(
   parameter int unsigned STEP_CYCLES = 4,
   parameter int unsigned DEAD_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic sel_dead,
   output logic tick
);

   localparam int unsigned N_MAX = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
   localparam int unsigned CW    = (N_MAX > 1) ? $clog2(N_MAX) : 1;
   localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] last;

   assign last = sel_dead ? DEAD_LAST : STEP_LAST;
   assign tick = (cnt == last);

   // Clear has priority so every RAMP/DEAD entry starts a full period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Command sequencer for the motor PWM: slews duty one LSB per tick and
// inserts ramp-to-zero plus dead-time around every direction reversal.
module motor_ramp_ctrl
   import motor_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 4,
   parameter int unsigned DEAD_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_duty,
   input  logic              cmd_dir,
   input  logic              estop,
   output logic [DUTY_W-1:0] duty,
   output logic              dir,
   output logic              busy,
   output logic              at_target
);

   state_t            state, state_n;
   logic [DUTY_W-1:0] duty_n;
   logic              dir_n;
   logic [DUTY_W-1:0] tgt_duty, tgt_duty_n;
   logic              tgt_dir, tgt_dir_n;
   logic              rev_pend, rev_pend_n;
   logic [DUTY_W-1:0] goal;
   logic              accept_rev;
   logic              step_tick;
   logic              tick_clr;

   assign cmd_ready = (state == IDLE) & ~estop;
   assign busy      = (state == RAMP) | (state == DEAD);
   assign at_target = (state == IDLE);
   assign tick_clr  = (state_n != state);

   ramp_tick_gen #(
      .STEP_CYCLES (STEP_CYCLES),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .clr      (tick_clr),
      .en       (busy),
      .sel_dead (state == DEAD),
      .tick     (step_tick)
   );

   // Next-state, duty slew and target bookkeeping
   always_comb begin
      state_n    = state;
      duty_n     = duty;
      dir_n      = dir;
      tgt_duty_n = tgt_duty;
      tgt_dir_n  = tgt_dir;
      rev_pend_n = rev_pend;
      accept_rev = 1'b0;
      goal       = rev_pend ? '0 : tgt_duty;

      if (estop) begin
         state_n    = ESTOP;
         duty_n     = '0;
         rev_pend_n = 1'b0;
         tgt_duty_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  accept_rev = (cmd_dir != dir);
                  tgt_duty_n = cmd_duty;
                  tgt_dir_n  = cmd_dir;
                  rev_pend_n = accept_rev;
                  if (accept_rev) begin
                     state_n = (duty != '0) ? RAMP : DEAD;
                  end else if (cmd_duty != duty) begin
                     state_n = RAMP;
                  end
               end
            end
            RAMP: begin
               if (step_tick) begin
                  if (duty < goal) begin
                     duty_n = duty + DUTY_W'(1);
                  end else if (duty > goal) begin
                     duty_n = duty - DUTY_W'(1);
                  end
                  if (duty_n == goal) begin
                     state_n = rev_pend ? DEAD : IDLE;
                  end
               end
            end
            DEAD: begin
               // Duty is already zero here, so flipping dir is safe
               if (step_tick) begin
                  dir_n      = tgt_dir;
                  rev_pend_n = 1'b0;
                  state_n    = (tgt_duty == '0) ? IDLE : RAMP;
               end
            end
            ESTOP: begin
               state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         duty     <= '0;
         dir      <= 1'b0;
         tgt_duty <= '0;
         tgt_dir  <= 1'b0;
         rev_pend <= 1'b0;
      end else begin
         state    <= state_n;
         duty     <= duty_n;
         dir      <= dir_n;
         tgt_duty <= tgt_duty_n;
         tgt_dir  <= tgt_dir_n;
         rev_pend <= rev_pend_n;
      end
   end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed scenarios plus random commands,
// checked every cycle against a behavioural timing model.
module tb_motor_ramp_ctrl;
   import motor_pkg::*;

   localparam int STEP  = 4;
   localparam int DEADC = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic [DUTY_W-1:0] cmd_duty = '0;
   logic              cmd_dir = 1'b0;
   logic              estop = 1'b0;
   logic              cmd_ready;
   logic [DUTY_W-1:0] duty;
   logic              dir;
   logic              busy;
   logic              at_target;

   int checks = 0;
   int errors = 0;

   // Model: mode 0 idle, 1 ramping, 2 dead-time, 3 stopped
   int m_mode, m_duty, m_dir, m_tgt, m_tdir, m_rev, m_wait;
   int prev_duty, prev_dir;

   motor_ramp_ctrl #(
      .STEP_CYCLES (STEP),
      .DEAD_CYCLES (DEADC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_duty  (cmd_duty),
      .cmd_dir   (cmd_dir),
      .estop     (estop),
      .duty      (duty),
      .dir       (dir),
      .busy      (busy),
      .at_target (at_target)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_duty = 0; m_dir = 0; m_tgt = 0; m_tdir = 0; m_rev = 0; m_wait = 0;
      prev_duty = 0; prev_dir = 0;
   endtask

   // One clock edge of the command/ramp/dead-time rules, in elapsed-cycle terms
   task automatic model_step();
      int goal;
      if (estop) begin
         m_mode = 3; m_duty = 0; m_rev = 0; m_tgt = 0;
      end else if (m_mode == 0) begin
         if (cmd_valid) begin
            m_tgt  = int'(cmd_duty);
            m_tdir = int'(cmd_dir);
            m_rev  = (m_tdir != m_dir) ? 1 : 0;
            if (m_rev != 0) begin
               if (m_duty != 0) begin m_mode = 1; m_wait = STEP; end
               else begin m_mode = 2; m_wait = DEADC; end
            end else if (m_tgt != m_duty) begin
               m_mode = 1; m_wait = STEP;
            end
         end
      end else if (m_mode == 1) begin
         goal = (m_rev != 0) ? 0 : m_tgt;
         m_wait--;
         if (m_wait == 0) begin
            m_duty = m_duty + ((goal > m_duty) ? 1 : -1);
            m_wait = STEP;
            if (m_duty == goal) begin
               if (m_rev != 0) begin m_mode = 2; m_wait = DEADC; end
               else m_mode = 0;
            end
         end
      end else if (m_mode == 2) begin
         m_wait--;
         if (m_wait == 0) begin
            m_dir = m_tdir; m_rev = 0;
            if (m_tgt == 0) m_mode = 0;
            else begin m_mode = 1; m_wait = STEP; end
         end
      end else begin
         m_mode = 0;
      end
   endtask

   task automatic check_all();
      chk("duty", 32'(duty), 32'(m_duty));
      chk("dir", 32'(dir), 32'(m_dir));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0 && !estop));
      chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk("at_target", 32'(at_target), 32'(m_mode == 0));
      if (32'(dir) !== 32'(prev_dir))
         chk("dir_flip_duty_zero", 32'(prev_duty) | 32'(duty), 32'd0);
      prev_duty = int'(duty);
      prev_dir  = int'(dir);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic drive(input logic v, input int d, input logic r, input logic e);
      cmd_valid = v;
      cmd_duty  = DUTY_W'(d);
      cmd_dir   = r;
      estop     = e;
   endtask

   task automatic accept(input int d, input logic r);
      drive(1'b1, d, r, 1'b0);
      cyc();
      drive(1'b0, 0, r, 1'b0);
   endtask

   initial begin
      int t;
      model_reset();

      // Reset with random command inputs
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'($urandom);
         cmd_duty  = DUTY_W'($urandom);
         cmd_dir   = 1'($urandom);
         @(posedge clk); #1;
         chk("rst_duty", 32'(duty), 32'd0);
         chk("rst_dir", 32'(dir), 32'd0);
         chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
         chk("rst_at_target", 32'(at_target), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      drive(1'b0, 0, 1'b0, 1'b0);
      rst = 1'b0;

      // Ramp up 0 -> 8
      accept(8, 1'b0);
      run_n(3);
      chk("up_before_first_step", 32'(duty), 32'd0);
      cyc();
      chk("up_first_step", 32'(duty), 32'd1);
      run_n(27);
      chk("up_busy_at_31", 32'(busy), 32'd1);
      cyc();
      chk("up_duty_at_32", 32'(duty), 32'd8);
      chk("up_busy_at_32", 32'(busy), 32'd0);
      chk("up_ready_at_32", 32'(cmd_ready), 32'd1);

      // Ramp down 8 -> 3
      accept(3, 1'b0);
      run_n(19);
      chk("down_duty_at_19", 32'(duty), 32'd4);
      cyc();
      chk("down_duty_at_20", 32'(duty), 32'd3);
      chk("down_dir", 32'(dir), 32'd0);
      chk("down_at_target", 32'(at_target), 32'd1);
      accept(8, 1'b0);
      run_n(20);
      chk("reup_duty", 32'(duty), 32'd8);

      // Reversal 8/dir0 -> 5/dir1
      accept(5, 1'b1);
      run_n(32);
      chk("rev_duty_zero_at_32", 32'(duty), 32'd0);
      chk("rev_dir_at_32", 32'(dir), 32'd0);
      chk("rev_busy_at_32", 32'(busy), 32'd1);
      run_n(7);
      chk("rev_dir_at_39", 32'(dir), 32'd0);
      cyc();
      chk("rev_dir_at_40", 32'(dir), 32'd1);
      chk("rev_duty_at_40", 32'(duty), 32'd0);
      run_n(20);
      chk("rev_duty_at_60", 32'(duty), 32'd5);
      chk("rev_at_target_60", 32'(at_target), 32'd1);

      // Emergency stop mid-ramp at duty 5
      accept(9, 1'b1);
      run_n(2);
      chk("estop_pre_duty", 32'(duty), 32'd5);
      drive(1'b0, 0, 1'b1, 1'b1);
      cyc();
      chk("estop_duty", 32'(duty), 32'd0);
      chk("estop_ready", 32'(cmd_ready), 32'd0);
      drive(1'b1, 12, 1'b0, 1'b1);
      run_n(4);
      chk("estop_hold_duty", 32'(duty), 32'd0);
      chk("estop_hold_dir", 32'(dir), 32'd1);
      drive(1'b0, 0, 1'b1, 1'b0);
      cyc();
      chk("estop_rel_at_target", 32'(at_target), 32'd1);
      chk("estop_rel_duty", 32'(duty), 32'd0);
      chk("estop_rel_ready", 32'(cmd_ready), 32'd1);
      run_n(3);
      chk("estop_not_queued", 32'(busy), 32'd0);

      // Random commands with occasional estop pulses
      for (int i = 0; i < 400; i++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_duty  = DUTY_W'($urandom);
         cmd_dir   = 1'($urandom);
         estop     = ($urandom_range(0, 59) == 0);
         cyc();
      end

      // Settle, then async reset in the middle of a ramp
      drive(1'b0, 0, 1'b0, 1'b0);
      run_n(140);
      t = (int'(duty) < 8) ? 15 : 0;
      accept(t, dir);
      run_n(8);
      chk("arst_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_duty", 32'(duty), 32'd0);
      chk("arst_dir", 32'(dir), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();

      // Same-value command is accepted without becoming busy
      drive(1'b1, 0, 1'b0, 1'b0);
      cyc();
      chk("same_busy", 32'(busy), 32'd0);
      drive(1'b0, 0, 1'b0, 1'b0);
      run_n(5);
      chk("same_busy_later", 32'(busy), 32'd0);
      chk("same_at_target", 32'(at_target), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
